// File: rtl/if_stage.sv
// Instruction fetch with IF/ID register: instr valid 2 cycles after a granted REQ, peak 1 instr per 2 cycles.
// Backpressure: a decode stall parks one response in a skid entry and fetching pauses in HOLD until stall drops.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] tgt_q, tgt_d;
  logic        kill_q, kill_d;
  fetch_t      skid_q, skid_d;
  fetch_t      ifid_q, ifid_d;
  logic        valid_q, valid_d;

  logic [31:0] redir_tgt;
  fetch_t      rsp_dat;
  fetch_t      new_dat;
  logic        new_vld;

  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign rsp_dat   = {imem_rdata, addr_q};

  // Next-state, fetch control and IF/ID load selection.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tgt_d    = tgt_q;
    kill_d   = kill_q;
    skid_d   = skid_q;
    imem_req = 1'b0;
    new_vld  = 1'b0;
    new_dat  = rsp_dat;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        addr_d  = RESET_PC;
      end

      REQ: begin
        imem_req = 1'b1;
        // The request stays up at the old address; its response gets discarded.
        if (redirect) begin
          kill_d = 1'b1;
          tgt_d  = redir_tgt;
        end
        if (imem_gnt) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = REQ;
            addr_d  = redirect ? redir_tgt : tgt_q;
          end else if (!stall) begin
            new_vld = 1'b1;
            new_dat = rsp_dat;
            state_d = REQ;
            addr_d  = addr_q + 32'd4;
          end else begin
            skid_d  = rsp_dat;
            state_d = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          tgt_d  = redir_tgt;
        end
      end

      HOLD: begin
        if (redirect) begin
          state_d = REQ;
          addr_d  = redir_tgt;
        end else if (!stall) begin
          new_vld = 1'b1;
          new_dat = skid_q;
          state_d = REQ;
          addr_d  = skid_q.pc + 32'd4;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Bubbles keep the last PC so the decoder only ever sees a known opcode.
    ifid_d  = ifid_q;
    valid_d = valid_q;
    if (redirect) begin
      ifid_d.instr = NOP_INSTR;
      valid_d      = 1'b0;
    end else if (!stall) begin
      if (new_vld) begin
        ifid_d  = new_dat;
        valid_d = 1'b1;
      end else begin
        ifid_d.instr = NOP_INSTR;
        valid_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      tgt_q   <= RESET_PC;
      kill_q  <= 1'b0;
      skid_q  <= '0;
      ifid_q  <= {NOP_INSTR, 32'h0000_0000};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      kill_q  <= kill_d;
      skid_q  <= skid_d;
      ifid_q  <= ifid_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr = addr_q;
  assign instr     = ifid_q.instr;
  assign pc        = ifid_q.pc;
  assign valid     = valid_q;

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_gnt) |=> (imem_req && $stable(imem_addr)));

  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req |-> (imem_addr[1:0] == 2'b00));

endmodule
